requant_stage: RTL and testbench

Per-channel requantization stage downstream of the convolution accumulator (the `addn`/`regn` accumulate loop). Takes finished signed accumulator words tagged with an output-channel index, adds the channel bias, scales by a Q31 fixed-point multiplier with a rounding right shift, adds the output zero point, and clamps to int8 with optional ReLU. It is a 4-stage valid/ready pipeline with a writable per-channel parameter table.

---
 rtl/fomo_pkg.sv | 18 +
 rtl/rq_param_ram.sv | 44 ++++
 rtl/requant_stage.sv | 177 +++++++++++++++++
 tb/tb_requant_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fomo_pkg.sv
// Shared constants for the requantization datapath.
//   ACC_W      accumulator / bias width (signed)
//   MULT_W     Q31 multiplier width (signed)
//   SH_W       per-channel extra right-shift width (unsigned)
//   OUT_W      output width (signed)
//   NCH        channel parameter table depth
//   Q31_FRAC   fractional bits of the multiplier
//   INT8_MIN / INT8_MAX   saturation bounds of the int8 output
package fomo_pkg;
   localparam int ACC_W    = 32;
   localparam int MULT_W   = 32;
   localparam int SH_W     = 5;
   localparam int OUT_W    = 8;
   localparam int NCH      = 16;
   localparam int Q31_FRAC = 31;
   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;
endpackage

// File: rtl/rq_param_ram.sv
// Per-channel requantization parameter table.
// One synchronous write port, one combinational read port. Entries are not
// reset; a channel reads as undefined until software has written it.
// Ports:
//   clk                      clock
//   we, wr_ch                write strobe and entry index
//   wr_bias/wr_mult/wr_shift write data
//   rd_ch                    read index
//   rd_bias/rd_mult/rd_shift read data (combinational)
module rq_param_ram #(
   parameter int ACC_W  = fomo_pkg::ACC_W,
   parameter int MULT_W = fomo_pkg::MULT_W,
   parameter int SH_W   = fomo_pkg::SH_W,
   parameter int NCH    = fomo_pkg::NCH,
   parameter int CH_W   = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [ACC_W-1:0]  wr_bias,
   input  logic [MULT_W-1:0] wr_mult,
   input  logic [SH_W-1:0]   wr_shift,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [ACC_W-1:0]  rd_bias,
   output logic [MULT_W-1:0] rd_mult,
   output logic [SH_W-1:0]   rd_shift
);
   import fomo_pkg::*;

   localparam int WORD_W = ACC_W + MULT_W + SH_W;

   logic [WORD_W-1:0] mem [NCH];

   // The write lands on the clock edge, so a word reading the same entry in
   // the write cycle still sees the previous contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_ch] <= {wr_bias, wr_mult, wr_shift};
      end
   end

   assign {rd_bias, rd_mult, rd_shift} = mem[rd_ch];

endmodule

// File: rtl/requant_stage.sv
// Per-channel requantization of finished accumulator words to int8.
// Four-stage valid/ready pipeline:
//   S1  table lookup, sum = acc + bias (one guard bit, no wrap)
//   S2  prod = sum * mult (full signed product)
//   S3  rounding right shift by 31 + shift (round half toward +inf)
//   S4  add zero point, clamp to int8 (lower bound = zp when ReLU enabled)
// Any stall freezes every stage, bubbles included.
// Ports:
//   clk, clr                        clock, async active-high reset
//   in_valid/in_ready               input handshake
//   in_acc, in_ch, in_last          accumulator word, channel, frame marker
//   out_valid/out_ready             output handshake
//   out_data, out_last              int8 result, delayed frame marker
//   cfg_we, cfg_ch                  table write strobe and entry
//   cfg_bias, cfg_mult, cfg_shift   table write data
//   out_zp, relu_en                 output zero point and ReLU enable (static while busy)
module requant_stage #(
   parameter int ACC_W  = fomo_pkg::ACC_W,
   parameter int MULT_W = fomo_pkg::MULT_W,
   parameter int SH_W   = fomo_pkg::SH_W,
   parameter int NCH    = fomo_pkg::NCH,
   parameter int OUT_W  = fomo_pkg::OUT_W,
   parameter int CH_W   = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ACC_W-1:0]  in_acc,
   input  logic [CH_W-1:0]   in_ch,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_bias,
   input  logic [MULT_W-1:0] cfg_mult,
   input  logic [SH_W-1:0]   cfg_shift,
   input  logic [OUT_W-1:0]  out_zp,
   input  logic              relu_en
);
   import fomo_pkg::*;

   localparam int SUM_W  = ACC_W + 1;
   localparam int PROD_W = SUM_W + MULT_W;
   // One extra bit so adding the rounding constant can never overflow.
   localparam int RND_W  = PROD_W + 1;
   // Shift is at least Q31_FRAC, so the shifted value fits in this width.
   localparam int R_W    = RND_W - Q31_FRAC;
   localparam int V_W    = R_W + 1;

   logic [ACC_W-1:0]  rd_bias;
   logic [MULT_W-1:0] rd_mult;
   logic [SH_W-1:0]   rd_shift;

   rq_param_ram #(
      .ACC_W  (ACC_W),
      .MULT_W (MULT_W),
      .SH_W   (SH_W),
      .NCH    (NCH),
      .CH_W   (CH_W)
   ) u_param_ram (
      .clk      (clk),
      .we       (cfg_we),
      .wr_ch    (cfg_ch),
      .wr_bias  (cfg_bias),
      .wr_mult  (cfg_mult),
      .wr_shift (cfg_shift),
      .rd_ch    (in_ch),
      .rd_bias  (rd_bias),
      .rd_mult  (rd_mult),
      .rd_shift (rd_shift)
   );

   logic stall;

   logic                     v1, last1;
   logic signed [SUM_W-1:0]  sum1;
   logic signed [MULT_W-1:0] mult1;
   logic [SH_W-1:0]          shift1;

   logic                     v2, last2;
   logic signed [PROD_W-1:0] prod2;
   logic [SH_W-1:0]          shift2;

   logic                     v3, last3;
   logic signed [R_W-1:0]    r3;

   logic                     v4, last4;
   logic [OUT_W-1:0]         data4;

   logic signed [SUM_W-1:0]  sum_c;
   logic signed [PROD_W-1:0] prod_c;
   logic [6:0]               t_c;
   logic signed [RND_W-1:0]  rnd_c;
   logic signed [RND_W-1:0]  rsum_c;
   logic signed [R_W-1:0]    r_c;
   logic signed [V_W-1:0]    v_c;
   logic signed [V_W-1:0]    lo_c;
   logic signed [V_W-1:0]    hi_c;
   logic signed [V_W-1:0]    clamp_c;

   assign stall     = v4 & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v4;
   assign out_data  = data4;
   assign out_last  = last4;

   // S1: bias add with a guard bit.
   assign sum_c = {in_acc[ACC_W-1], in_acc} + {rd_bias[ACC_W-1], rd_bias};

   // S2: full-precision signed product.
   assign prod_c = PROD_W'(sum1) * PROD_W'(mult1);

   // S3: add half an LSB of the result, then arithmetic shift (floor).
   assign t_c    = 7'(Q31_FRAC) + 7'(shift2);
   assign rnd_c  = RND_W'(1) << (t_c - 7'd1);
   assign rsum_c = {prod2[PROD_W-1], prod2} + rnd_c;
   assign r_c    = R_W'(rsum_c >>> t_c);

   // S4: zero point and saturation, compared at full width.
   assign v_c  = V_W'(r3) + V_W'($signed(out_zp));
   assign lo_c = relu_en ? V_W'($signed(out_zp)) : V_W'(INT8_MIN);
   assign hi_c = V_W'(INT8_MAX);

   always_comb begin
      clamp_c = v_c;
      if (v_c < lo_c) begin
         clamp_c = lo_c;
      end else if (v_c > hi_c) begin
         clamp_c = hi_c;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         v1     <= 1'b0;
         last1  <= 1'b0;
         sum1   <= '0;
         mult1  <= '0;
         shift1 <= '0;
         v2     <= 1'b0;
         last2  <= 1'b0;
         prod2  <= '0;
         shift2 <= '0;
         v3     <= 1'b0;
         last3  <= 1'b0;
         r3     <= '0;
         v4     <= 1'b0;
         last4  <= 1'b0;
         data4  <= '0;
      end else if (!stall) begin
         // in_ready is high whenever we get here, so in_valid is a transfer.
         v1     <= in_valid;
         last1  <= in_last;
         sum1   <= sum_c;
         mult1  <= rd_mult;
         shift1 <= rd_shift;

         v2     <= v1;
         last2  <= last1;
         prod2  <= prod_c;
         shift2 <= shift1;

         v3     <= v2;
         last3  <= last2;
         r3     <= r_c;

         v4     <= v3;
         last4  <= last3;
         data4  <= OUT_W'(clamp_c);
      end
   end

endmodule

// File: tb/tb_requant_stage.sv
module tb_requant_stage;
   import fomo_pkg::*;

   localparam int CH_W = $clog2(NCH);

   logic              clk = 1'b0;
   logic              clr;
   logic              in_valid;
   logic              in_ready;
   logic [ACC_W-1:0]  in_acc;
   logic [CH_W-1:0]   in_ch;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [ACC_W-1:0]  cfg_bias;
   logic [MULT_W-1:0] cfg_mult;
   logic [SH_W-1:0]   cfg_shift;
   logic [OUT_W-1:0]  out_zp;
   logic              relu_en;

   always #5 clk = ~clk;

   requant_stage dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_ch     (in_ch),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_bias  (cfg_bias),
      .cfg_mult  (cfg_mult),
      .cfg_shift (cfg_shift),
      .out_zp    (out_zp),
      .relu_en   (relu_en)
   );

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   dir_q[$];
   exp_t e;

   int sh_bias  [NCH];
   int sh_mult  [NCH];
   int sh_shift [NCH];

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   bit mon_en  = 0;

   bit              held_v = 0;
   logic [OUT_W-1:0] held_d;
   logic            held_l;

   task automatic chk(string tag, longint got, longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: exact rational arithmetic, floor((sum*mult)/2^t + 1/2).
   function automatic int model(int acc, int bias, int mult, int sh, int zp, bit relu);
      logic signed [127:0] num, den, q;
      longint s, v, lo;
      s   = longint'(acc) + longint'(bias);
      num = s;
      num = num * mult;
      den = 128'sd1 <<< (Q31_FRAC + sh);
      num = num + (den / 2);
      q   = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
      v  = longint'(q) + longint'(zp);
      lo = relu ? longint'(zp) : longint'(-128);
      if (v < lo) v = lo;
      if (v > longint'(127)) v = longint'(127);
      return int'(v);
   endfunction

   always @(negedge clk) begin
      if (mon_en && !clr) begin
         chk("in_ready", in_ready, !(out_valid && !out_ready));
         if (held_v) begin
            chk("hold_data", out_data, held_d);
            chk("hold_last", out_last, held_l);
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         held_l = out_last;
         if (in_valid && in_ready) begin
            exp_q.push_back('{model($signed(in_acc), sh_bias[in_ch], sh_mult[in_ch],
                                    sh_shift[in_ch], $signed(out_zp), relu_en), in_last});
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("data", $signed(out_data), e.data);
               chk("last", out_last, e.last);
               if (dir_q.size() != 0) chk("directed", $signed(out_data), dir_q.pop_front());
            end
         end
      end else begin
         held_v = 0;
      end
      if (cfg_we) begin
         sh_bias[cfg_ch]  = $signed(cfg_bias);
         sh_mult[cfg_ch]  = $signed(cfg_mult);
         sh_shift[cfg_ch] = int'(cfg_shift);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(int ch, int b, int m, int s);
      cfg_we    = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_bias  = b;
      cfg_mult  = m;
      cfg_shift = SH_W'(s);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send(int acc, int ch, bit last, int expv);
      in_valid = 1'b1;
      in_acc   = acc;
      in_ch    = CH_W'(ch);
      in_last  = last;
      dir_q.push_back(expv);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
      chk("drain_empty", exp_q.size(), 0);
      chk("dir_empty", dir_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, wi, stalls, outs0, a;
      clr = 1'b1; in_valid = 0; in_acc = '0; in_ch = '0; in_last = 0;
      out_ready = 1'b1; cfg_we = 0; cfg_ch = '0; cfg_bias = '0; cfg_mult = '0;
      cfg_shift = '0; out_zp = '0; relu_en = 0;
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      clr = 1'b0;
      mon_en = 1;
      tick();

      // Basic scaling and latency.
      cfg_wr(0, 0, 32'h4000_0000, 0);
      cfg_wr(5, 24, 32'h4000_0000, 2);
      out_zp = -8'sd3; relu_en = 0;
      in_valid = 1; in_acc = 100; in_ch = 0; in_last = 0;
      dir_q.push_back(47);
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
      end
      chk("latency", lat, 4);
      tick();
      drain();

      // Rounding and saturation.
      out_zp = 0;
      send(3, 0, 0, 2);
      send(-3, 0, 0, -1);
      send(1, 0, 0, 1);
      send(1000, 0, 0, 127);
      send(-1000, 0, 0, -128);
      drain();
      relu_en = 1; out_zp = -8'sd3;
      send(-100, 0, 0, -3);
      drain();
      relu_en = 0; out_zp = 0;
      send(1000, 5, 0, 127);
      send(100, 5, 1, 16);
      drain();

      // Backpressure: out_ready low in stream cycles 3..6.
      wi = 0; stalls = 0; outs0 = n_out;
      for (int c = 0; c < 40 && wi < 8; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         in_valid  = 1; in_acc = 10 * wi; in_ch = 0; in_last = (wi == 7);
         @(negedge clk);
         if (!in_ready) stalls++;
         if (in_ready) begin dir_q.push_back(5 * wi); wi++; end
         @(posedge clk); #1;
      end
      in_valid = 0; in_last = 0; out_ready = 1;
      drain();
      chk("bp_stall_cycles", stalls, 3);
      chk("bp_out_count", n_out - outs0, 8);

      // Config write racing an accept on the same channel.
      out_zp = -8'sd3;
      cfg_we = 1; cfg_ch = 0; cfg_bias = 0; cfg_mult = 32'h2000_0000; cfg_shift = 0;
      send(100, 0, 0, 47);
      cfg_we = 0;
      send(100, 0, 0, 22);
      drain();

      // Reset with words in flight.
      out_ready = 0;
      send(100, 0, 0, 0);
      send(200, 0, 0, 0);
      send(300, 0, 1, 0);
      tick();
      chk("pre_clr_valid", out_valid, 1);
      clr = 1; exp_q.delete(); dir_q.delete();
      #1;
      chk("clr_out_valid", out_valid, 0);
      chk("clr_out_data", out_data, 0);
      chk("clr_out_last", out_last, 0);
      tick(); tick();
      clr = 0; out_ready = 1;
      outs0 = n_out;
      @(negedge clk);
      chk("post_clr_ready", in_ready, 1);
      tick();
      repeat (10) tick();
      chk("post_clr_no_out", n_out - outs0, 0);

      // Randomized streams against the reference model.
      for (int ch = 0; ch < NCH; ch++)
         cfg_wr(ch, int'($urandom) >>> $urandom_range(0, 31), int'($urandom),
                int'($urandom_range(0, 31)));
      for (int rnd = 0; rnd < 4; rnd++) begin
         out_zp  = OUT_W'($urandom);
         relu_en = $urandom_range(0, 1) == 1;
         for (int c = 0; c < 150; c++) begin
            a = int'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) a = -a;
            in_valid  = $urandom_range(0, 3) != 0;
            in_acc    = a;
            in_ch     = CH_W'($urandom);
            in_last   = $urandom_range(0, 7) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            cfg_we    = $urandom_range(0, 9) == 0;
            cfg_ch    = CH_W'($urandom);
            cfg_bias  = $urandom >> $urandom_range(0, 31);
            cfg_mult  = $urandom;
            cfg_shift = SH_W'($urandom);
            tick();
         end
         in_last = 0;
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
